usb_nrzi_tx: RTL

Transmit line encoder directly downstream of the serializer (piso).
- Consumes the serial bit stream (LSB-first, one bit per clk) with its valid/last qualifiers.
- Performs USB bit stuffing and NRZI encoding, then appends EOP (SE0 then J).
- Drives the full-speed dp/dm line pair with output enable to the transceiver; returns a ready signal so upstream pauses during stuff and EOP cycles.

---
 rtl/usb_nrzi_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/usb_nrzi_tx.sv
// USB full-speed transmit encoder: bit stuffing, NRZI, and EOP generation.
// Outputs are registered; each accepted bit is driven for the following bit time.
module usb_nrzi_tx #(
  parameter int STUFF_LIMIT  = 6,
  parameter int EOP_SE0_BITS = 2,
  parameter int CNT_WIDTH    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic bit_val,
  input  logic bit_last,
  output logic bit_ready,
  output logic dp_out,
  output logic dm_out,
  output logic tx_oe,
  output logic tx_busy,
  output logic eop_done
);

  typedef enum logic [2:0] {IDLE, DATA, STUFF, EOP_SE0, EOP_J} state_t;

  localparam logic [CNT_WIDTH-1:0] STUFF_MAX = CNT_WIDTH'(STUFF_LIMIT);
  localparam logic [CNT_WIDTH-1:0] SE0_MAX   = CNT_WIDTH'(EOP_SE0_BITS);

  state_t               state_q, state_d;
  logic                 line_q, line_d;   // 1 = J, 0 = K
  logic                 dp_q, dp_d;
  logic                 dm_q, dm_d;
  logic                 tx_oe_q, tx_oe_d;
  logic                 eop_done_q, eop_done_d;
  logic                 last_pend_q, last_pend_d;
  logic [CNT_WIDTH-1:0] ones_cnt_q, ones_cnt_d;
  logic [CNT_WIDTH-1:0] eop_cnt_q, eop_cnt_d;

  logic                 accept;
  logic                 nrzi_line;
  logic [CNT_WIDTH-1:0] ones_inc;

  assign bit_ready = (state_q == IDLE) || (state_q == DATA);
  assign accept    = bit_val && bit_ready;
  assign nrzi_line = bit_in ? line_q : ~line_q;
  assign ones_inc  = ones_cnt_q + 1'b1;

  assign dp_out   = dp_q;
  assign dm_out   = dm_q;
  assign tx_oe    = tx_oe_q;
  assign tx_busy  = (state_q != IDLE);
  assign eop_done = eop_done_q;

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    dp_d        = dp_q;
    dm_d        = dm_q;
    tx_oe_d     = tx_oe_q;
    eop_done_d  = 1'b0;
    last_pend_d = last_pend_q;
    ones_cnt_d  = ones_cnt_q;
    eop_cnt_d   = eop_cnt_q;

    case (state_q)
      IDLE, DATA: begin
        // With no bit offered the line simply holds (idle J, or an underrun stall).
        if (accept) begin
          line_d     = nrzi_line;
          dp_d       = nrzi_line;
          dm_d       = ~nrzi_line;
          tx_oe_d    = 1'b1;
          ones_cnt_d = bit_in ? ones_inc : '0;
          if (bit_in && (ones_inc == STUFF_MAX)) begin
            state_d     = STUFF;
            last_pend_d = bit_last;
          end else if (bit_last) begin
            state_d   = EOP_SE0;
            eop_cnt_d = '0;
          end else begin
            state_d = DATA;
          end
        end
      end

      STUFF: begin
        line_d     = ~line_q;
        dp_d       = ~line_q;
        dm_d       = line_q;
        ones_cnt_d = '0;
        if (last_pend_q) begin
          state_d     = EOP_SE0;
          eop_cnt_d   = '0;
          last_pend_d = 1'b0;
        end else begin
          state_d = DATA;
        end
      end

      EOP_SE0: begin
        // Entered while the final data/stuff bit is still on the line.
        if (eop_cnt_q == SE0_MAX) begin
          state_d = EOP_J;
          line_d  = 1'b1;
          dp_d    = 1'b1;
          dm_d    = 1'b0;
        end else begin
          dp_d      = 1'b0;
          dm_d      = 1'b0;
          eop_cnt_d = eop_cnt_q + 1'b1;
        end
      end

      EOP_J: begin
        state_d     = IDLE;
        tx_oe_d     = 1'b0;
        eop_done_d  = 1'b1;
        line_d      = 1'b1;
        dp_d        = 1'b1;
        dm_d        = 1'b0;
        ones_cnt_d  = '0;
        eop_cnt_d   = '0;
        last_pend_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      line_q      <= 1'b1;
      dp_q        <= 1'b1;
      dm_q        <= 1'b0;
      tx_oe_q     <= 1'b0;
      eop_done_q  <= 1'b0;
      last_pend_q <= 1'b0;
      ones_cnt_q  <= '0;
      eop_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      dp_q        <= dp_d;
      dm_q        <= dm_d;
      tx_oe_q     <= tx_oe_d;
      eop_done_q  <= eop_done_d;
      last_pend_q <= last_pend_d;
      ones_cnt_q  <= ones_cnt_d;
      eop_cnt_q   <= eop_cnt_d;
    end
  end

endmodule
